character_action_fsm: RTL and testbench

CHARACTER_ACTION_FSM -- requirements
Module: character_action_fsm

---
 rtl/char_pkg.sv | 26 ++
 rtl/char_charge_counter.sv | 31 +++
 rtl/character_action_fsm.sv | 186 ++++++++++++++++++
 tb/tb_character_action_fsm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared action-state encoding and default physics constants for the character
// movement FSM and the display-state controller.
package char_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_LEFT           = 3'd1,
    ST_RIGHT          = 3'd2,
    ST_CHARGE         = 3'd3,
    ST_JUMP           = 3'd4,
    ST_COLLISION      = 3'd5,
    ST_FALL_TO_GROUND = 3'd6,
    ST_HOLD           = 3'd7
  } char_state_e;

  localparam int DEF_SIGNED_PHY_WIDTH = 17;
  localparam int DEF_MAX_VEL_Y        = 10;
  localparam int DEF_CHARGE_SHIFT     = 5;
  localparam int DEF_MAX_CHARGE       = 32;
  localparam int DEF_WALK_VEL         = 2;
  localparam int DEF_JUMP_VEL_X       = 3;
  localparam int DEF_GRAVITY          = 1;
  localparam int DEF_HOLD_TIME        = 8;
  localparam int CHARGE_LEVEL_W       = 6;

endpackage

// File: rtl/char_charge_counter.sv
// Jump charge accumulator: saturating up-counter with synchronous clear,
// advancing only on physics ticks.
module char_charge_counter
  import char_pkg::*;
#(
  parameter int MAX_CHARGE = DEF_MAX_CHARGE,
  parameter int WIDTH      = CHARGE_LEVEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MAX_CHARGE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      if (clear) begin
        count <= '0;
      end else if (inc && (count < COUNT_MAX)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/character_action_fsm.sv
// Character action state machine: grounded walking, charged jumps, airborne
// gravity, wall bounces and hard-landing freeze, all stepped by the physics tick.
module character_action_fsm
  import char_pkg::*;
#(
  parameter int SIGNED_PHY_WIDTH = DEF_SIGNED_PHY_WIDTH,
  parameter int MAX_VEL_Y        = DEF_MAX_VEL_Y,
  parameter int CHARGE_SHIFT     = DEF_CHARGE_SHIFT,
  parameter int MAX_CHARGE       = DEF_MAX_CHARGE,
  parameter int WALK_VEL         = DEF_WALK_VEL,
  parameter int JUMP_VEL_X       = DEF_JUMP_VEL_X,
  parameter int GRAVITY          = DEF_GRAVITY,
  parameter int HOLD_TIME        = DEF_HOLD_TIME
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic                               character_clk,
  input  logic                               btn_left,
  input  logic                               btn_right,
  input  logic                               btn_jump,
  input  logic                               on_ground,
  input  logic                               hit_wall,
  output logic [2:0]                         char_state,
  output logic signed [SIGNED_PHY_WIDTH-1:0] vel_y,
  output logic signed [SIGNED_PHY_WIDTH-1:0] vel_x,
  output logic                               face_dir,
  output logic [CHARGE_LEVEL_W-1:0]          charge_level
);

  localparam int W      = SIGNED_PHY_WIDTH;
  localparam int HOLD_W = (HOLD_TIME > 1) ? $clog2(HOLD_TIME) : 1;

  localparam logic signed [W-1:0] VEL_ZERO      = '0;
  localparam logic signed [W-1:0] VEL_ONE       = W'(1);
  localparam logic signed [W-1:0] WALK_POS      = W'(WALK_VEL);
  localparam logic signed [W-1:0] WALK_NEG      = W'(-WALK_VEL);
  localparam logic signed [W-1:0] JUMP_X_POS    = W'(JUMP_VEL_X);
  localparam logic signed [W-1:0] JUMP_X_NEG    = W'(-JUMP_VEL_X);
  localparam logic signed [W-1:0] GRAVITY_S     = W'(GRAVITY);
  localparam logic signed [W-1:0] VY_MIN        = W'(-MAX_VEL_Y);
  localparam logic signed [W-1:0] IMPACT_LIMIT  = W'(-(MAX_VEL_Y >> 1));
  localparam logic [HOLD_W-1:0]   HOLD_LAST     = HOLD_W'(HOLD_TIME - 1);
  localparam logic [CHARGE_LEVEL_W-1:0] CHARGE_FULL = CHARGE_LEVEL_W'(MAX_CHARGE);

  char_state_e            state, state_n;
  logic signed [W-1:0]    vel_x_n, vel_y_n;
  logic                   face_n;
  logic [HOLD_W-1:0]      hold_cnt, hold_n;
  logic                   impact, impact_n;
  logic                   charge_clear, charge_inc;

  logic [31:0]            launch_prod, launch_mag;
  logic signed [W-1:0]    launch_vy, launch_vx;
  logic signed [W-1:0]    vy_dec, vy_fall;

  char_charge_counter #(
    .MAX_CHARGE (MAX_CHARGE),
    .WIDTH      (CHARGE_LEVEL_W)
  ) u_charge (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .tick  (character_clk),
    .clear (charge_clear),
    .inc   (charge_inc),
    .count (charge_level)
  );

  // Launch strength scales charge onto the vertical range, never below one.
  assign launch_prod = 32'(charge_level) * 32'(MAX_VEL_Y);
  assign launch_mag  = launch_prod >> CHARGE_SHIFT;
  assign launch_vy   = (launch_mag == '0) ? VEL_ONE : W'(launch_mag);
  assign vy_dec      = vel_y - GRAVITY_S;
  assign vy_fall     = (vy_dec < VY_MIN) ? VY_MIN : vy_dec;

  always_comb begin
    launch_vx = VEL_ZERO;
    if (btn_left && !btn_right) begin
      launch_vx = JUMP_X_NEG;
    end else if (btn_right && !btn_left) begin
      launch_vx = JUMP_X_POS;
    end
  end

  always_comb begin
    state_n      = state;
    vel_x_n      = vel_x;
    vel_y_n      = vel_y;
    face_n       = face_dir;
    hold_n       = hold_cnt;
    impact_n     = impact;
    charge_clear = 1'b0;
    charge_inc   = 1'b0;
    case (state)
      ST_IDLE, ST_LEFT, ST_RIGHT: begin
        vel_y_n = VEL_ZERO;
        if (!on_ground) begin
          state_n = ST_JUMP;
        end else if (btn_jump) begin
          state_n      = ST_CHARGE;
          vel_x_n      = VEL_ZERO;
          charge_clear = 1'b1;
        end else if (btn_left && !btn_right) begin
          state_n = ST_LEFT;
          vel_x_n = WALK_NEG;
          face_n  = 1'b1;
        end else if (btn_right && !btn_left) begin
          state_n = ST_RIGHT;
          vel_x_n = WALK_POS;
          face_n  = 1'b0;
        end else begin
          state_n = ST_IDLE;
          vel_x_n = VEL_ZERO;
        end
      end
      ST_CHARGE: begin
        if (!btn_jump || (charge_level == CHARGE_FULL)) begin
          state_n      = ST_JUMP;
          vel_y_n      = launch_vy;
          vel_x_n      = launch_vx;
          charge_clear = 1'b1;
        end else begin
          charge_inc = 1'b1;
        end
      end
      ST_JUMP: begin
        // Landing outranks a wall hit seen on the same tick.
        if (on_ground && (vel_y <= VEL_ZERO)) begin
          state_n  = ST_FALL_TO_GROUND;
          vel_x_n  = VEL_ZERO;
          vel_y_n  = VEL_ZERO;
          impact_n = (vel_y < IMPACT_LIMIT);
        end else begin
          vel_y_n = vy_fall;
          if (hit_wall) begin
            state_n = ST_COLLISION;
            vel_x_n = -vel_x;
          end
        end
      end
      ST_COLLISION: begin
        state_n = ST_JUMP;
      end
      ST_FALL_TO_GROUND: begin
        state_n  = impact ? ST_HOLD : ST_IDLE;
        hold_n   = '0;
        impact_n = 1'b0;
        vel_x_n  = VEL_ZERO;
        vel_y_n  = VEL_ZERO;
      end
      ST_HOLD: begin
        vel_x_n = VEL_ZERO;
        vel_y_n = VEL_ZERO;
        if (hold_cnt == HOLD_LAST) begin
          state_n = ST_IDLE;
          hold_n  = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      vel_x    <= '0;
      vel_y    <= '0;
      face_dir <= 1'b0;
      hold_cnt <= '0;
      impact   <= 1'b0;
    end else if (character_clk) begin
      state    <= state_n;
      vel_x    <= vel_x_n;
      vel_y    <= vel_y_n;
      face_dir <= face_n;
      hold_cnt <= hold_n;
      impact   <= impact_n;
    end
  end

  assign char_state = state;

endmodule

// File: tb/tb_character_action_fsm.sv
// Bench for character_action_fsm: vector table, directed multi-tick scenarios
// and randomized traffic compared against an integer model of the rules.
module tb_character_action_fsm;

  localparam int S_IDLE = 0, S_LEFT = 1, S_RIGHT = 2, S_CHARGE = 3;
  localparam int S_JUMP = 4, S_COLL = 5, S_FALL = 6, S_HOLD = 7;
  localparam int M_MAX_VEL_Y = 10, M_MAX_CHARGE = 32, M_WALK = 2, M_JUMP_X = 3;
  localparam int M_GRAVITY = 1, M_HOLD_TIME = 8;

  logic        sys_clk = 1'b0, sys_rst = 1'b1, character_clk = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic        on_ground = 1'b1, hit_wall = 1'b0;
  logic [2:0]  char_state;
  logic signed [16:0] vel_y, vel_x;
  logic        face_dir;
  logic [5:0]  charge_level;

  int checks = 0;
  int errors = 0;

  int m_state, m_vx, m_vy, m_face, m_charge, m_hold_left, m_hard;

  typedef struct {
    bit tk, l, r, j, g, w;
    int st, vx, vy, face, ch;
  } vec_t;
  vec_t vecs [0:12];

  character_action_fsm dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .character_clk (character_clk),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_jump      (btn_jump),
    .on_ground     (on_ground),
    .hit_wall      (hit_wall),
    .char_state    (char_state),
    .vel_y         (vel_y),
    .vel_x         (vel_x),
    .face_dir      (face_dir),
    .charge_level  (charge_level)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_state = S_IDLE; m_vx = 0; m_vy = 0; m_face = 0; m_charge = 0;
    m_hold_left = 0; m_hard = 0;
  endtask

  // One physics tick of the movement rules, written directly from the behaviour.
  task automatic model_step(input bit l, input bit r, input bit j, input bit g, input bit w);
    case (m_state)
      S_IDLE, S_LEFT, S_RIGHT: begin
        m_vy = 0;
        if (!g) m_state = S_JUMP;
        else if (j) begin m_state = S_CHARGE; m_charge = 0; m_vx = 0; end
        else if (l && !r) begin m_state = S_LEFT; m_vx = -M_WALK; m_face = 1; end
        else if (r && !l) begin m_state = S_RIGHT; m_vx = M_WALK; m_face = 0; end
        else begin m_state = S_IDLE; m_vx = 0; end
      end
      S_CHARGE: begin
        if (!j || m_charge == M_MAX_CHARGE) begin
          m_state = S_JUMP;
          m_vy = (m_charge * M_MAX_VEL_Y) / M_MAX_CHARGE;
          if (m_vy < 1) m_vy = 1;
          m_vx = (l && !r) ? -M_JUMP_X : ((r && !l) ? M_JUMP_X : 0);
          m_charge = 0;
        end else begin
          m_charge = m_charge + 1;
        end
      end
      S_JUMP: begin
        if (g && m_vy <= 0) begin
          m_hard = (m_vy < -(M_MAX_VEL_Y / 2)) ? 1 : 0;
          m_state = S_FALL; m_vx = 0; m_vy = 0;
        end else begin
          m_vy = m_vy - M_GRAVITY;
          if (m_vy < -M_MAX_VEL_Y) m_vy = -M_MAX_VEL_Y;
          if (w) begin m_state = S_COLL; m_vx = -m_vx; end
        end
      end
      S_COLL: m_state = S_JUMP;
      S_FALL: begin
        if (m_hard != 0) begin m_state = S_HOLD; m_hold_left = M_HOLD_TIME; end
        else m_state = S_IDLE;
        m_hard = 0;
      end
      default: begin
        m_hold_left = m_hold_left - 1;
        if (m_hold_left == 0) m_state = S_IDLE;
      end
    endcase
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string name);
    check_val({name, ".state"}, int'(char_state), m_state);
    check_val({name, ".vel_x"}, int'(vel_x), m_vx);
    check_val({name, ".vel_y"}, int'(vel_y), m_vy);
    check_val({name, ".face"}, int'(face_dir), m_face);
    check_val({name, ".charge"}, int'(charge_level), m_charge);
  endtask

  // Drive at a falling edge, let one rising edge act, return at the next falling edge.
  task automatic apply_stimulus(input bit tk, input bit l, input bit r, input bit j,
                                input bit g, input bit w);
    character_clk = tk; btn_left = l; btn_right = r; btn_jump = j;
    on_ground = g; hit_wall = w;
    @(posedge sys_clk);
    if (tk) model_step(l, r, j, g, w);
    @(negedge sys_clk);
  endtask

  initial begin
    vecs = '{
      '{1,0,0,0,1,0, S_IDLE,   0, 0, 0, 0},
      '{0,1,0,0,1,0, S_IDLE,   0, 0, 0, 0},
      '{1,1,0,0,1,0, S_LEFT,  -2, 0, 1, 0},
      '{1,1,1,0,1,0, S_IDLE,   0, 0, 1, 0},
      '{1,0,1,0,1,0, S_RIGHT,  2, 0, 0, 0},
      '{1,0,1,1,1,0, S_CHARGE, 0, 0, 0, 0},
      '{1,0,0,1,1,0, S_CHARGE, 0, 0, 0, 1},
      '{1,0,0,0,1,0, S_JUMP,   0, 1, 0, 0},
      '{1,0,0,0,0,0, S_JUMP,   0, 0, 0, 0},
      '{0,0,0,0,1,0, S_JUMP,   0, 0, 0, 0},
      '{1,0,0,0,0,0, S_JUMP,   0,-1, 0, 0},
      '{1,0,0,0,1,0, S_FALL,   0, 0, 0, 0},
      '{1,0,0,0,1,0, S_IDLE,   0, 0, 0, 0}
    };
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_output("reset");
    sys_rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].tk, vecs[i].l, vecs[i].r, vecs[i].j, vecs[i].g, vecs[i].w);
      check_val($sformatf("vec%0d.state", i), int'(char_state), vecs[i].st);
      check_val($sformatf("vec%0d.vel_x", i), int'(vel_x), vecs[i].vx);
      check_val($sformatf("vec%0d.vel_y", i), int'(vel_y), vecs[i].vy);
      check_val($sformatf("vec%0d.face", i), int'(face_dir), vecs[i].face);
      check_val($sformatf("vec%0d.charge", i), int'(charge_level), vecs[i].ch);
    end

    // Sixteen counted charge ticks then release.
    apply_stimulus(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 0, 1, 1, 0);
    check_val("charge16.level", int'(charge_level), 16);
    apply_stimulus(1, 0, 0, 0, 1, 0);
    check_val("launch16.state", int'(char_state), S_JUMP);
    check_val("launch16.vel_y", int'(vel_y), 5);
    check_val("launch16.vel_x", int'(vel_x), 0);
    check_val("launch16.charge", int'(charge_level), 0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0);
      check_output("arc16");
    end
    apply_stimulus(1, 0, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0, 1, 0);
    check_val("land16.state", int'(char_state), S_IDLE);

    // Full charge auto-launches while jump is still held.
    apply_stimulus(1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 32; i++) apply_stimulus(1, 0, 1, 1, 1, 0);
    check_val("charge32.state", int'(char_state), S_CHARGE);
    check_val("charge32.level", int'(charge_level), 32);
    apply_stimulus(1, 0, 1, 1, 1, 0);
    check_val("auto.state", int'(char_state), S_JUMP);
    check_val("auto.vel_y", int'(vel_y), 10);
    check_val("auto.vel_x", int'(vel_x), 3);
    check_val("auto.charge", int'(charge_level), 0);

    apply_stimulus(1, 0, 0, 0, 0, 1);
    check_val("wall.state", int'(char_state), S_COLL);
    check_val("wall.vel_x", int'(vel_x), -3);
    check_val("wall.vel_y", int'(vel_y), 9);
    apply_stimulus(1, 0, 0, 0, 0, 1);
    check_val("wall_back.state", int'(char_state), S_JUMP);
    check_val("wall_back.vel_x", int'(vel_x), -3);
    for (int i = 0; i < 25; i++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0);
      check_output("long_fall");
    end
    check_val("clamp.vel_y", int'(vel_y), -10);
    apply_stimulus(1, 0, 0, 0, 1, 1);
    check_val("land_wall.state", int'(char_state), S_FALL);
    check_val("land_wall.vel_x", int'(vel_x), 0);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, 1, 0, 1, 1, 0);
      check_val($sformatf("hold%0d.state", i), int'(char_state), S_HOLD);
      check_val($sformatf("hold%0d.vel_x", i), int'(vel_x), 0);
    end
    apply_stimulus(1, 1, 0, 1, 1, 0);
    check_val("hold_exit.state", int'(char_state), S_IDLE);

    // Asynchronous reset between ticks while charging.
    apply_stimulus(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 1, 1, 0);
    check_val("precharge.level", int'(charge_level), 3);
    #2 sys_rst = 1'b1;
    #1;
    model_reset();
    check_output("async_rst");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    apply_stimulus(1, 0, 0, 0, 1, 0);
    check_output("post_rst");

    for (int i = 0; i < 800; i++) begin
      bit tk, l, r, j, g, w;
      tk = ($urandom_range(0, 3) != 0);
      l  = $urandom_range(0, 1) != 0;
      r  = $urandom_range(0, 1) != 0;
      j  = ($urandom_range(0, 2) != 0);
      g  = ($urandom_range(0, 4) != 0);
      w  = ($urandom_range(0, 3) == 0);
      apply_stimulus(tk, l, r, j, g, w);
      check_output("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
